// File: rtl/ext_pkg.sv
// Shared types and constants for the sign/zero-extension arbiter slice.
package ext_pkg;
  typedef enum logic {EXT_B8 = 1'b0, EXT_FULL = 1'b1} ext_len_e;
  typedef enum logic {EXT_ZERO = 1'b0, EXT_SIGN = 1'b1} ext_mode_e;
  localparam int EXT_BYTE_W = 8;
endpackage

// File: rtl/ext_unit.sv
// Combinational N-to-M bit sign/zero extender with an optional byte-only mode.
module ext_unit import ext_pkg::*; #(
  parameter int N = 16,
  parameter int M = 32
) (
  input  logic [N-1:0] i_data,
  input  logic         i_sign,
  input  logic         i_len,
  output logic [M-1:0] o_data
);

  logic w_sbit;
  logic w_fill;

  always_comb begin
    w_sbit = (i_len == EXT_FULL) ? i_data[N-1] : i_data[EXT_BYTE_W-1];
    w_fill = (i_sign == EXT_SIGN) && w_sbit;
    o_data = {M{w_fill}};
    // Byte mode drops the operand's upper bits entirely.
    if (i_len == EXT_FULL) o_data[N-1:0] = i_data;
    else                   o_data[EXT_BYTE_W-1:0] = i_data[EXT_BYTE_W-1:0];
  end

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin shared extension datapath: one grant per cycle, registered result
// returned with the winning requester's ID over a valid/ready channel.
module ext_arbiter import ext_pkg::*; #(
  parameter int N    = 16,
  parameter int M    = 32,
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ-1:0]   req_signed,
  input  logic [NREQ-1:0]   req_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_data,
  output logic [IDW-1:0]    out_id
);

  if (N < 8) begin : g_chk_n
    $fatal(1, "ext_arbiter: N must be >= 8");
  end
  if (M < N) begin : g_chk_m
    $fatal(1, "ext_arbiter: M must be >= N");
  end
  if (NREQ < 2) begin : g_chk_nreq
    $fatal(1, "ext_arbiter: NREQ must be >= 2");
  end

  logic           r_out_valid;
  logic [M-1:0]   r_out_data;
  logic [IDW-1:0] r_out_id;
  logic [IDW-1:0] r_rr_ptr;

  logic           w_can_accept;
  logic           w_found;
  logic           w_accept;
  logic [IDW-1:0] w_gnt;
  int             w_dist;
  int             w_best;
  logic [N-1:0]   w_gnt_data;
  logic           w_gnt_sign;
  logic           w_gnt_len;
  logic [M-1:0]   w_ext;

  // Gating with rst_n keeps req_ready low while the block is held in reset.
  assign w_can_accept = rst_n && (!r_out_valid || out_ready);

  // Pick the valid requester closest to rr_ptr going upward with wrap.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_dist  = 0;
    w_best  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        w_dist = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr)) : (i + NREQ - int'(r_rr_ptr));
        if (w_dist < w_best) begin
          w_best  = w_dist;
          w_gnt   = i[IDW-1:0];
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    w_gnt_sign = 1'b0;
    w_gnt_len  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i[IDW-1:0] == w_gnt) begin
        w_gnt_data = req_data[i*N +: N];
        w_gnt_sign = req_signed[i];
        w_gnt_len  = req_len[i];
      end
    end
  end

  assign w_accept = w_found && w_can_accept;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt] = 1'b1;
  end

  ext_unit #(.N(N), .M(M)) u_ext (
    .i_data (w_gnt_data),
    .i_sign (w_gnt_sign),
    .i_len  (w_gnt_len),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ext;
      r_out_id    <= w_gnt;
      r_rr_ptr    <= (w_gnt == IDW'(NREQ-1)) ? '0 : (w_gnt + IDW'(1));
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: driver predicts grants and results from the
// arbitration/extension rules, a monitor checks every presented output.
module tb_ext_arbiter;
  localparam int N    = 16;
  localparam int M    = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_data = '0;
  logic [NREQ-1:0]   req_signed = '0;
  logic [NREQ-1:0]   req_len = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [M-1:0]      out_data;
  logic [IDW-1:0]    out_id;

  ext_arbiter #(.N(N), .M(M), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_signed(req_signed), .req_len(req_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0]   data;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   pend_new = 1'b0;
  int   m_ptr = 0;
  bit   m_valid = 1'b0;
  int   mon_exp = 0;

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension as integer arithmetic: interpret as two's complement when signed.
  function automatic logic [M-1:0] model_ext(input logic [N-1:0] d, input bit s, input bit len);
    longint v;
    int     w;
    w = len ? N : 8;
    v = len ? longint'(d) : longint'(d) % 256;
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v[M-1:0];
  endfunction

  task automatic drive(input logic [NREQ-1:0] v, input logic [N-1:0] d0, input logic [N-1:0] d1,
                       input logic [NREQ-1:0] s, input logic [NREQ-1:0] l, input logic ordy);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    req_valid  = v;
    req_data   = {d1, d0};
    req_signed = s;
    req_len    = l;
    out_ready  = ordy;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && ((v >> idx) & 1) != 0) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0 && (!m_valid || ordy)) exp_rdy = NREQ'(1) << g;
    chk("req_ready", M'(req_ready), M'(exp_rdy));
    pend_new = 1'b0;
    if (exp_rdy != '0) begin
      q.push_back('{data: model_ext((g == 0) ? d0 : d1, ((s >> g) & 1) != 0, ((l >> g) & 1) != 0),
                    id: IDW'(g)});
      pend_new = 1'b1;
      m_valid  = 1'b1;
      m_ptr    = (g + 1) % NREQ;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: runs after the driver each cycle and checks the presented output.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      mon_exp = q.size() - (pend_new ? 1 : 0);
      chk("out_valid", M'(out_valid), M'(mon_exp > 0));
      if (out_valid && mon_exp > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_id", M'(out_id), M'(q[0].id));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    // Reset state, with requests pending so req_ready gating is exercised.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", M'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_id", M'(out_id), '0);
    chk("rst_req_ready", M'(req_ready), '0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    drive(2'b01, 16'h8001, 16'h0, 2'b01, 2'b01, 1'b1);
    drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
    chk("dir_sfull", out_data, 32'hFFFF8001);
    chk("dir_sfull_id", M'(out_id), 32'h0);

    drive(2'b01, 16'h8001, 16'h0, 2'b00, 2'b01, 1'b1);
    drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
    chk("dir_zfull", out_data, 32'h00008001);

    drive(2'b01, 16'h1280, 16'h0, 2'b01, 2'b00, 1'b1);
    drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
    chk("dir_sbyte", out_data, 32'hFFFFFF80);

    drive(2'b10, 16'h0, 16'h1280, 2'b00, 2'b00, 1'b1);
    drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
    chk("dir_zbyte", out_data, 32'h00000080);
    chk("dir_zbyte_id", M'(out_id), 32'h1);

    // Both requesters streaming with the consumer always ready.
    for (int i = 0; i < 6; i++)
      drive(2'b11, 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom), 1'b1);

    // Stall for three cycles, then release.
    for (int i = 0; i < 3; i++)
      drive(2'b11, 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom), 1'b0);
    for (int i = 0; i < 2; i++)
      drive(2'b11, 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom), 1'b1);

    // Asynchronous reset while a result is pending.
    drive(2'b11, 16'h7FFF, 16'h8000, 2'b11, 2'b11, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", M'(out_valid), '0);
    chk("async_rst_ready", M'(req_ready), '0);
    q.delete();
    m_valid  = 1'b0;
    m_ptr    = 0;
    pend_new = 1'b0;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    drive(2'b11, 16'h00FF, 16'h0001, 2'b11, 2'b00, 1'b1);
    drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
    chk("post_rst_id", M'(out_id), 32'h0);
    chk("post_rst_data", out_data, 32'hFFFFFFFF);

    // Randomized traffic with intermittent back-pressure.
    for (int i = 0; i < 400; i++)
      drive(2'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom),
            ($urandom_range(0, 3) != 0));

    for (int i = 0; i < 3; i++)
      drive(2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 1'b1);
    #3;
    chk("drained", M'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ext_arbiter.md
Name: ext_arbiter

Overview:
- Shares one sign/zero-extension datapath (N to M bits) among NREQ requesters, for example decode-immediate and load-data paths.
- Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle.
- The extended result is registered and returned with the winning requester's ID over a valid/ready output channel.
- The block sits between the decode/load stages and the execute/writeback consumers.

Parameters:
- N, 16, input data width (N >= 8)
- M, 32, output data width (M >= N)
- NREQ, 2, number of requesters (NREQ >= 2)
- IDW, $clog2(NREQ), requester ID width (derived, localparam)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_data  in  NREQ*N  per-requester operand; slice i is bits [i*N +: N]
- req_signed  in  NREQ  1 = sign extend, 0 = zero extend
- req_len  in  NREQ  0 = use low 8 bits of operand, 1 = use all N bits
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- out_data  out  M  extended result
- out_id  out  IDW  index of the requester that produced out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, round-robin pointer rr_ptr=0. req_ready is combinational, so it is 0 during reset.
- can_accept = !out_valid || out_ready.
- Grant selection:
  - g = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g] = can_accept; every other req_ready bit = 0.
  - If no req_valid is high, req_ready = 0.
- Accept event (req_valid[g] && req_ready[g]) on a clock edge:
  - out_data <= ext(req_data[g], req_signed[g], req_len[g])
  - out_id <= g
  - out_valid <= 1
  - rr_ptr <= (g+1) mod NREQ
- Without an accept, rr_ptr holds.
- Drain: out_valid && out_ready with no accept in the same cycle makes out_valid <= 0.
- Drain and accept in the same cycle: the new result is loaded and out_valid stays 1. This gives full throughput of one result per cycle.
- Latency: exactly 1 cycle from accept to out_valid.
- Stall: while out_valid && !out_ready, out_data, out_id and out_valid hold stable and all req_ready = 0.
- Extension function ext(d, s, len):
  - len=1: sbit = d[N-1]; result = {(M-N) copies of (s ? sbit : 0), d}. If M==N, result = d unchanged.
  - len=0: sbit = d[7]; result = {(M-8) copies of (s ? sbit : 0), d[7:0]}; d[N-1:8] is ignored.
- Requesters may hold or change req_data while not granted. Data is sampled only on the accept edge.
- A requester holding req_valid is guaranteed a grant within NREQ accept events.
- Reset mid-operation: a pending output is discarded (out_valid drops immediately) and the arbiter restarts at requester 0.
- Elaboration: assert N >= 8, M >= N, NREQ >= 2. A violation is a fatal elaboration error.

Decomposition:
- Package ext_pkg:
  - typedef enum logic {EXT_B8=1'b0, EXT_FULL=1'b1} ext_len_e
  - typedef enum logic {EXT_ZERO=1'b0, EXT_SIGN=1'b1} ext_mode_e
  - localparam EXT_BYTE_W = 8
- Sub-module ext_unit (combinational, parameters N and M): implements ext(). ext_arbiter instantiates it once on the muxed granted operand.
- Round-robin grant logic, rr_ptr and the output register stay in ext_arbiter.

Test Plan (N=16, M=32, NREQ=2):
- Requester 0 only, data 16'h8001, signed=1, len=1, out_ready=1 → one cycle after accept: out_valid=1, out_data=32'hFFFF8001, out_id=0.
- Same request with signed=0 → out_data=32'h00008001.
- len=0, data 16'h1280: signed=1 gives 32'hFFFFFF80; signed=0 gives 32'h00000080. Upper byte 8'h12 has no effect.
- Both requesters valid continuously, out_ready=1 → out_id sequence 0,1,0,1,...; out_valid stays 1 every cycle after the first; req_ready alternates 01,10.
- Hold out_ready=0 for 3 cycles with out_valid=1 → out_data and out_id stable, req_ready=00. Raise out_ready → the held result drains and the next grant loads in the same cycle with no bubble.
- Assert rst_n=0 asynchronously while out_valid=1 → out_valid=0 before the next clock edge. After release, with both valid, the first out_id is 0.
